// File: rtl/sdr_wr_split_pkg.sv
// Shared SDR write-path definitions: FSM state codes, page size and the
// host-address / controller-address field layout used when packing sdr_waddr.
package sdr_wr_split_pkg;

  localparam int unsigned PAGE_HW = 512;

  localparam int unsigned COL_W  = 9;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned BANK_W = 2;

  // Field offsets in the linear host halfword address
  localparam int unsigned HCOL_LSB  = 0;
  localparam int unsigned HROW_LSB  = 9;
  localparam int unsigned HBANK_LSB = 22;

  // Field offsets in the controller address (bit 9 is a fixed zero)
  localparam int unsigned WCOL_LSB  = 0;
  localparam int unsigned WROW_LSB  = 10;
  localparam int unsigned WBANK_LSB = 23;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;

  function automatic logic [31:0] pack_waddr(input logic [23:0] addr);
    logic [31:0] w;
    w = 32'd0;
    w[WBANK_LSB +: BANK_W] = addr[HBANK_LSB +: BANK_W];
    w[WROW_LSB  +: ROW_W]  = addr[HROW_LSB  +: ROW_W];
    w[WCOL_LSB  +: COL_W]  = addr[HCOL_LSB  +: COL_W];
    return w;
  endfunction

endpackage

// File: rtl/sdr_wr_split_if.sv
// Host command/data stream plus SDR controller write port, bundled.
// slave = the splitter's view, master = the surrounding host/controller.
interface sdr_wr_split_if;

  logic        host_cmd_vld;
  logic        host_cmd_rdy;
  logic [23:0] host_addr;
  logic [11:0] host_len;
  logic        host_wdata_vld;
  logic [15:0] host_wdata;
  logic        host_wdata_rdy;
  logic        sdr_wr_req;
  logic [31:0] sdr_waddr;
  logic [11:0] sdr_wr_byte_cnt;
  logic        sdr_wr_ack;
  logic [15:0] sdr_wdata_in;
  logic        sdr_wdata_wr;
  logic        sdr_wr_ready;
  logic        busy;
  logic        done;

  modport slave (
    input  host_cmd_vld, host_addr, host_len, host_wdata_vld, host_wdata,
    input  sdr_wr_ack, sdr_wr_ready,
    output host_cmd_rdy, host_wdata_rdy, sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt,
    output sdr_wdata_in, sdr_wdata_wr, busy, done
  );

  modport master (
    output host_cmd_vld, host_addr, host_len, host_wdata_vld, host_wdata,
    output sdr_wr_ack, sdr_wr_ready,
    input  host_cmd_rdy, host_wdata_rdy, sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt,
    input  sdr_wdata_in, sdr_wdata_wr, busy, done
  );

endinterface

// File: rtl/sdr_wr_split.sv
// Splits a host write command into controller segments that never cross a
// 512-halfword row and never exceed MAX_SEG_HW; data passes through unbuffered.
module sdr_wr_split
  import sdr_wr_split_pkg::*;
#(
  parameter int unsigned MAX_SEG_HW = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  sdr_wr_split_if.slave bus
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_cmd_rdy;
  logic        r_done;
  logic [23:0] r_cur_addr;
  logic [11:0] r_rem;
  logic [9:0]  r_seg;
  logic [9:0]  r_fwd_cnt;
  logic [31:0] r_waddr;
  logic [11:0] r_byte_cnt;

  logic        w_accept;
  logic        w_active;
  logic        w_wdata_rdy;
  logic        w_xfer;
  logic [9:0]  w_fwd_cnt_nxt;
  logic        w_seg_done;
  logic [11:0] w_rem_nxt;
  logic [9:0]  w_room;
  logic [9:0]  w_seg_rc;
  logic [9:0]  w_seg;

  assign w_accept      = (r_state == ST_IDLE) && r_cmd_rdy && bus.host_cmd_vld;
  assign w_active      = (r_state == ST_REQ) || (r_state == ST_DATA);
  assign w_wdata_rdy   = w_active && bus.sdr_wr_ready && (r_fwd_cnt < r_seg);
  assign w_xfer        = bus.host_wdata_vld && w_wdata_rdy;
  assign w_fwd_cnt_nxt = r_fwd_cnt + {9'd0, w_xfer};
  assign w_seg_done    = (w_fwd_cnt_nxt == r_seg);
  assign w_rem_nxt     = r_rem - {2'd0, r_seg};

  // Room left in the current row is 1..512, so every candidate fits in 10 bits
  assign w_room   = 10'(PAGE_HW) - {1'b0, r_cur_addr[COL_W-1:0]};
  assign w_seg_rc = (r_rem < {2'd0, w_room}) ? r_rem[9:0] : w_room;
  assign w_seg    = (w_seg_rc < 10'(MAX_SEG_HW)) ? w_seg_rc : 10'(MAX_SEG_HW);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (bus.host_len != 12'd0)) w_state_nxt = ST_CALC;
        else                                     w_state_nxt = ST_IDLE;
      end
      ST_CALC: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.sdr_wr_ack) w_state_nxt = w_seg_done ? ST_NEXT : ST_DATA;
        else                w_state_nxt = ST_REQ;
      end
      ST_DATA: begin
        if (w_seg_done) w_state_nxt = ST_NEXT;
        else            w_state_nxt = ST_DATA;
      end
      ST_NEXT: begin
        if (w_rem_nxt == 12'd0) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_CALC;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, command-ready and completion pulse; rdy stays low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cmd_rdy <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_rdy <= (w_state_nxt == ST_IDLE);
      r_done    <= (w_accept && (bus.host_len == 12'd0)) ||
                   ((r_state == ST_NEXT) && (w_rem_nxt == 12'd0));
    end
  end

  // Command bookkeeping and the segment request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr <= 24'd0;
      r_rem      <= 12'd0;
      r_seg      <= 10'd0;
      r_fwd_cnt  <= 10'd0;
      r_waddr    <= 32'd0;
      r_byte_cnt <= 12'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cur_addr <= bus.host_addr;
            r_rem      <= bus.host_len;
          end
        end
        ST_CALC: begin
          r_seg      <= w_seg;
          r_fwd_cnt  <= 10'd0;
          r_waddr    <= pack_waddr(r_cur_addr);
          r_byte_cnt <= {1'b0, w_seg, 1'b0};
        end
        ST_REQ, ST_DATA: r_fwd_cnt <= w_fwd_cnt_nxt;
        ST_NEXT: begin
          r_cur_addr <= r_cur_addr + {14'd0, r_seg};
          r_rem      <= w_rem_nxt;
        end
        default: r_fwd_cnt <= r_fwd_cnt;
      endcase
    end
  end

  assign bus.host_cmd_rdy    = r_cmd_rdy;
  assign bus.host_wdata_rdy  = w_wdata_rdy;
  assign bus.sdr_wr_req      = (r_state == ST_REQ);
  assign bus.sdr_waddr       = r_waddr;
  assign bus.sdr_wr_byte_cnt = r_byte_cnt;
  assign bus.sdr_wdata_in    = bus.host_wdata;
  assign bus.sdr_wdata_wr    = w_xfer;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.done            = r_done;

endmodule

// File: tb/tb_sdr_wr_split.sv
// Bench for sdr_wr_split: directed vector table, reset corners and random
// commands against an arithmetic segment model; two DUTs cover MAX_SEG_HW.
module tb_sdr_wr_split;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdr_wr_split_if if0();
  sdr_wr_split_if if1();

  sdr_wr_split #(.MAX_SEG_HW(512)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sdr_wr_split #(.MAX_SEG_HW(64))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic        sel = 1'b0;
  logic        t_cmd_vld = 1'b0, t_wvld = 1'b0, t_ack = 1'b0, t_ready = 1'b0;
  logic [23:0] t_addr = 24'd0;
  logic [11:0] t_len = 12'd0;
  logic [15:0] t_wdata = 16'd0;

  assign if0.host_cmd_vld   = sel ? 1'b0 : t_cmd_vld;
  assign if0.host_addr      = t_addr;
  assign if0.host_len       = t_len;
  assign if0.host_wdata_vld = sel ? 1'b0 : t_wvld;
  assign if0.host_wdata     = t_wdata;
  assign if0.sdr_wr_ack     = sel ? 1'b0 : t_ack;
  assign if0.sdr_wr_ready   = sel ? 1'b0 : t_ready;
  assign if1.host_cmd_vld   = sel ? t_cmd_vld : 1'b0;
  assign if1.host_addr      = t_addr;
  assign if1.host_len       = t_len;
  assign if1.host_wdata_vld = sel ? t_wvld : 1'b0;
  assign if1.host_wdata     = t_wdata;
  assign if1.sdr_wr_ack     = sel ? t_ack : 1'b0;
  assign if1.sdr_wr_ready   = sel ? t_ready : 1'b0;

  logic        o_cmd_rdy, o_wrdy, o_req, o_wr, o_busy, o_done;
  logic [31:0] o_waddr;
  logic [11:0] o_bc;
  logic [15:0] o_wd;
  assign o_cmd_rdy = sel ? if1.host_cmd_rdy    : if0.host_cmd_rdy;
  assign o_wrdy    = sel ? if1.host_wdata_rdy  : if0.host_wdata_rdy;
  assign o_req     = sel ? if1.sdr_wr_req      : if0.sdr_wr_req;
  assign o_waddr   = sel ? if1.sdr_waddr       : if0.sdr_waddr;
  assign o_bc      = sel ? if1.sdr_wr_byte_cnt : if0.sdr_wr_byte_cnt;
  assign o_wd      = sel ? if1.sdr_wdata_in    : if0.sdr_wdata_in;
  assign o_wr      = sel ? if1.sdr_wdata_wr    : if0.sdr_wdata_wr;
  assign o_busy    = sel ? if1.busy            : if0.busy;
  assign o_done    = sel ? if1.done            : if0.done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_waddr[$];
  int exp_bc[$];
  int exp_cum[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the command row by row with plain integer arithmetic
  task automatic build_model(input int addr, input int len, input int maxseg);
    int a, r, s, tot;
    exp_waddr.delete(); exp_bc.delete(); exp_cum.delete();
    a = addr; r = len; tot = 0;
    while (r > 0) begin
      s = r;
      if (512 - (a % 512) < s) s = 512 - (a % 512);
      if (maxseg < s) s = maxseg;
      exp_waddr.push_back((a / 4194304) * 8388608 + ((a / 512) % 8192) * 1024 + (a % 512));
      exp_bc.push_back(2 * s);
      tot += s;
      exp_cum.push_back(tot);
      a = (a + s) % 16777216;
      r -= s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    t_cmd_vld = 1'b0; t_wvld = 1'b0; t_ack = 1'b0; t_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},     32'(o_req), 32'd0);
    chk({tag, "_wr"},      32'(o_wr), 32'd0);
    chk({tag, "_wrdy"},    32'(o_wrdy), 32'd0);
    chk({tag, "_busy"},    32'(o_busy), 32'd0);
    chk({tag, "_done"},    32'(o_done), 32'd0);
    chk({tag, "_cmd_rdy"}, 32'(o_cmd_rdy), 32'd0);
    chk({tag, "_waddr"},   o_waddr, 32'd0);
    chk({tag, "_bc"},      32'(o_bc), 32'd0);
  endtask

  task automatic run_cmd(input logic [23:0] addr, input logic [11:0] len, input int ack_dly,
                         input int stall_at, input int stall_len, input bit rnd, input int abort_at,
                         output int n_req, output logic [31:0] first_wa, output logic [11:0] last_bc);
    logic [15:0] data[$];
    int idx, seg_seen, wait_cnt, limit, lim_words, done_cyc;
    bit acc, req_hold, got_done;
    logic [31:0] hold_wa;
    logic [11:0] hold_bc;
    build_model(int'(addr), int'(len), sel ? 64 : 512);
    for (int i = 0; i < int'(len); i++) data.push_back(16'($urandom));
    n_req = 0; first_wa = 32'd0; last_bc = 12'd0;
    @(negedge clk);
    t_addr = addr; t_len = len; t_cmd_vld = 1'b1; t_wvld = 1'b0; t_ack = 1'b0; t_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      if (o_cmd_rdy) acc = 1'b1;
      @(negedge clk);
    end
    t_cmd_vld = 1'b0;
    chk("cmd_accept", 32'(acc), 32'd1);
    if (!acc) return;
    idx = 0; seg_seen = 0; wait_cnt = 0; req_hold = 1'b0; got_done = 1'b0; done_cyc = -1;
    hold_wa = 32'd0; hold_bc = 12'd0;
    limit = 40 * int'(len) + 40 * (ack_dly + 5) * (exp_waddr.size() + 1) + 50;
    for (int cyc = 0; cyc < limit && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      t_ready = !(cyc >= stall_at && cyc < stall_at + stall_len) && (!rnd || $urandom_range(3) != 0);
      t_wvld  = rnd ? ($urandom_range(3) != 0) : 1'b1;
      t_wdata = (idx < int'(len)) ? data[idx] : 16'hDEAD;
      if (o_req) begin
        t_ack = (wait_cnt >= ack_dly);
        wait_cnt++;
      end else begin
        t_ack = rnd ? 1'($urandom_range(1)) : 1'b0;
      end
      t_cmd_vld = o_busy && !o_done;
      #1;
      if (cyc == 0 && len != 12'd0) chk("busy_on", 32'(o_busy), 32'd1);
      if (t_cmd_vld) chk("cmd_holdoff", 32'(o_cmd_rdy), 32'd0);
      if (!t_ready) begin
        chk("rdy_stall", 32'(o_wrdy), 32'd0);
        chk("wr_stall", 32'(o_wr), 32'd0);
      end
      if (o_req) begin
        if (!req_hold) begin
          if (n_req < exp_waddr.size()) begin
            chk("waddr", o_waddr, 32'(exp_waddr[n_req]));
            chk("byte_cnt", 32'(o_bc), 32'(exp_bc[n_req]));
          end else begin
            chk("extra_req", 32'(n_req), 32'(exp_waddr.size()));
          end
          if (n_req == 0) first_wa = o_waddr;
          last_bc = o_bc;
          n_req++;
          seg_seen = n_req;
          hold_wa = o_waddr; hold_bc = o_bc; req_hold = 1'b1;
        end else begin
          chk("req_stable_wa", o_waddr, hold_wa);
          chk("req_stable_bc", 32'(o_bc), 32'(hold_bc));
        end
        if (t_ack) begin
          req_hold = 1'b0;
          wait_cnt = 0;
        end
      end
      if (o_wr) begin
        if (idx >= int'(len)) begin
          chk("extra_word", 32'(idx), 32'(len));
        end else begin
          chk("wdata", 32'(o_wd), 32'(data[idx]));
          lim_words = (seg_seen > 0 && seg_seen <= exp_cum.size()) ? exp_cum[seg_seen-1] : 0;
          chk("seg_bound", 32'(idx + 1 > lim_words), 32'd0);
          idx++;
        end
      end
      if (abort_at > 0 && idx >= abort_at) return;
      if (o_done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("done_nreq", 32'(n_req), 32'(exp_waddr.size()));
        chk("done_words", 32'(idx), 32'(len));
      end
    end
    if (!got_done) begin
      chk("timeout_done", 32'd0, 32'd1);
      do_reset();
      return;
    end
    if (len == 12'd0) chk("len0_done_lat", 32'(done_cyc), 32'd0);
    @(negedge clk);
    t_cmd_vld = 1'b0; t_wvld = 1'b0; t_ack = 1'b0;
    #1;
    chk("done_pulse", 32'(o_done), 32'd0);
    chk("busy_off", 32'(o_busy), 32'd0);
    chk("idle_rdy", 32'(o_cmd_rdy), 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [11:0] len;
    int          ack_dly;
    int          stall_at;
    int          stall_len;
    logic        dut_sel;
    int          exp_nreq;
    logic [31:0] exp_first_wa;
    logic [11:0] exp_last_bc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          nr;
    logic [31:0] fw;
    logic [11:0] lb;
    logic [23:0] ra;

    vecs[0] = '{24'h000010, 12'd16,   0,  0, 0, 1'b0, 1,  32'h00000010, 12'd32};
    vecs[1] = '{24'h0001F8, 12'd16,   0,  0, 0, 1'b0, 2,  32'h000001F8, 12'd16};
    vecs[2] = '{24'h000000, 12'd1200, 1,  0, 0, 1'b0, 3,  32'h00000000, 12'd352};
    vecs[3] = '{24'h000000, 12'd1200, 0,  0, 0, 1'b1, 19, 32'h00000000, 12'd96};
    vecs[4] = '{24'h000100, 12'd40,   0, 10, 5, 1'b0, 1,  32'h00000100, 12'd80};
    vecs[5] = '{24'hFFFFFC, 12'd8,   10,  0, 0, 1'b0, 2,  32'h01FFFDFC, 12'd8};
    vecs[6] = '{24'h123456, 12'd0,    0,  0, 0, 1'b0, 0,  32'h00000000, 12'd0};

    // Reset values on both instances, then ready from the first edge after release
    repeat (2) @(negedge clk);
    #1;
    sel = 1'b0; #1; chk_reset_outputs("rst0");
    sel = 1'b1; #1; chk_reset_outputs("rst1");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(o_cmd_rdy), 32'd0);
    @(negedge clk); #1;
    chk("rdy_after_rst", 32'(o_cmd_rdy), 32'd1);

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].dut_sel;
      run_cmd(vecs[v].addr, vecs[v].len, vecs[v].ack_dly, vecs[v].stall_at, vecs[v].stall_len,
              1'b0, 0, nr, fw, lb);
      chk($sformatf("vec%0d_nreq", v), 32'(nr), 32'(vecs[v].exp_nreq));
      chk($sformatf("vec%0d_first_wa", v), fw, vecs[v].exp_first_wa);
      chk($sformatf("vec%0d_last_bc", v), 32'(lb), 32'(vecs[v].exp_last_bc));
    end

    // Reset in the middle of a data phase, then a clean command
    sel = 1'b0;
    run_cmd(24'h000040, 12'd100, 0, 0, 0, 1'b0, 20, nr, fw, lb);
    t_wvld = 1'b0; t_ack = 1'b0; t_cmd_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk); #1;
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    run_cmd(24'h0001FC, 12'd10, 2, 0, 0, 1'b0, 0, nr, fw, lb);
    chk("post_abort_nreq", 32'(nr), 32'd2);
    chk("post_abort_first_wa", fw, 32'h000001FC);

    // Random commands, biased toward row ends and the top of the address space
    for (int r = 0; r < 24; r++) begin
      sel = 1'($urandom_range(1));
      ra = 24'($urandom);
      case ($urandom_range(5))
        0, 1:    ra[8:0] = 9'h1F0 + 9'($urandom_range(15));
        2:       ra = 24'hFFFF00 + 24'($urandom_range(255));
        default: ra = ra;
      endcase
      run_cmd(ra, ($urandom_range(7) == 0) ? 12'd0 : 12'($urandom_range(700, 1)),
              $urandom_range(3), 0, 0, 1'b1, 0, nr, fw, lb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_wr_split.md
SDR_WR_SPLIT -- requirements
Module: sdr_wr_split

Interface
REQ-001 The block SHALL have parameter MAX_SEG_HW, default 512, meaning the maximum halfwords per controller write segment (legal 1..512).
REQ-002 The block SHALL have port clk  in  1  clock.
REQ-003 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port host_cmd_vld  in  1  host write command valid.
REQ-005 The block SHALL have port host_cmd_rdy  out  1  command accepted when high with vld.
REQ-006 The block SHALL have port host_addr  in  24  linear halfword address {bank[23:22], row[21:9], col[8:0]}.
REQ-007 The block SHALL have port host_len  in  12  halfword count, 0..4095.
REQ-008 The block SHALL have ports host_wdata_vld  in  1, host_wdata  in  16, host_wdata_rdy  out  1, forming the host data stream.
REQ-009 The block SHALL have ports sdr_wr_req  out  1, sdr_waddr  out  32, sdr_wr_byte_cnt  out  12, sdr_wr_ack  in  1 (controller segment-accept pulse).
REQ-010 The block SHALL have ports sdr_wdata_in  out  16, sdr_wdata_wr  out  1, sdr_wr_ready  in  1 (controller write-FIFO not full).
REQ-011 The block SHALL have ports busy  out  1 (command in progress) and done  out  1 (one-cycle completion pulse).

Function
REQ-012 The block SHALL implement states IDLE, CALC, REQ, DATA and NEXT.
REQ-013 In IDLE, host_cmd_rdy SHALL be 1; on vld&rdy it SHALL latch addr and len into cur_addr and rem; len=0 SHALL pulse done the next cycle and stay in IDLE, otherwise go to CALC.
REQ-014 CALC SHALL compute seg = min(rem, 512 - cur_addr[8:0], MAX_SEG_HW) in one cycle, clear the segment data counter, and go to REQ.
REQ-015 In REQ, sdr_wr_req SHALL be held high until sdr_wr_ack is sampled high, and sdr_waddr and sdr_wr_byte_cnt SHALL stay stable throughout.
REQ-016 On ack, the block SHALL go to DATA, or go directly to NEXT if all seg words have already been forwarded.
REQ-017 sdr_waddr SHALL be {7'b0, bank, row, 1'b0, col}: bank on bits [24:23], row on [22:10], bit 9 = 0, col on [8:0].
REQ-018 sdr_wr_byte_cnt SHALL equal seg*2; 512 halfwords SHALL give 1024.
REQ-019 In REQ and DATA, host_wdata_rdy SHALL be sdr_wr_ready AND (forwarded count < seg); it SHALL be 0 in every other state.
REQ-020 Data forwarding SHALL be combinational with zero latency: sdr_wdata_wr = host_wdata_vld & host_wdata_rdy, and sdr_wdata_in = host_wdata.
REQ-021 DATA SHALL go to NEXT in the cycle after the last segment word is forwarded.
REQ-022 NEXT SHALL set cur_addr += seg (24-bit, modulo 2^24, so 0xFFFFFF wraps to 0) and rem -= seg.
REQ-023 From NEXT, rem=0 SHALL pulse done and go to IDLE; otherwise the block SHALL go to CALC.
REQ-024 A segment SHALL never cross a 512-halfword row boundary.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 sdr_wr_ack outside REQ SHALL be ignored.
REQ-027 A host_cmd_vld while busy SHALL be held off by host_cmd_rdy=0.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE; host_cmd_rdy=0 during reset and 1 from the first clock after release.
REQ-029 While rst_n=0, sdr_wr_req, sdr_wdata_wr, host_wdata_rdy, busy and done SHALL be 0, and sdr_waddr, sdr_wr_byte_cnt, cur_addr, rem, seg and the data counter SHALL be 0.
REQ-030 Reset asserted mid-command SHALL abort the command immediately; no partial state SHALL survive the reset.

Structure
REQ-031 The shared SDR package SHALL hold the state encodings, the PAGE_HW=512 constant, and the bank/row/col field offsets used by sdr_waddr packing.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Single segment: addr=0x000010, len=16 -> one req with waddr=0x00000010, byte_cnt=32; 16 sdr_wdata_wr pulses; done pulse; busy then falls.
REQ-034 Row crossing: addr=0x0001F8, len=16 -> req1 waddr=0x000001F8, byte_cnt=16; req2 waddr=0x00000400, byte_cnt=16.
REQ-035 Long command: addr=0, len=1200 -> waddr 0x0/0x400/0x800 with byte_cnt 1024/1024/352; MAX_SEG_HW=64 -> 19 segments, last byte_cnt=96.
REQ-036 Backpressure: sdr_wr_ready low for 5 cycles mid-segment -> host_wdata_rdy=0 and no sdr_wdata_wr in those cycles; data order intact; word count exact.
REQ-037 Wrap and ack delay: addr=0xFFFFFC, len=8 with ack delayed 10 cycles -> req1 waddr=0x01FFFDFC, byte_cnt=8; req2 waddr=0x00000000, byte_cnt=8; req held stable until ack.
REQ-038 Edge cases: len=0 -> done one cycle after acceptance, no req; rst_n low mid-DATA -> all outputs 0, IDLE, and the next command completes normally.
